// File: rtl/alarm_setter_if.sv
// ============================================================================
// Module      : alarm_setter_if
// Description : Alarm-settings bus between the alarm setter and its consumers.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface alarm_setter_if;
    logic       set_alarm;
    logic [6:0] set_minutes;
    logic [5:0] set_hours;
    logic       editing;
    logic       edit_field;
    logic [6:0] edit_minutes;
    logic [5:0] edit_hours;

    modport master (
        output set_alarm, set_minutes, set_hours,
        output editing, edit_field, edit_minutes, edit_hours
    );

    modport slave (
        input set_alarm, set_minutes, set_hours,
        input editing, edit_field, edit_minutes, edit_hours
    );
endinterface

`default_nettype wire

// File: rtl/alarm_setter.sv
// ============================================================================
// Module      : alarm_setter
// Description : Two-button alarm editor: sync, debounce, hours/minutes edit FSM,
//               edit timeout and single-cycle commit strobe.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module alarm_setter #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TIMEOUT_CYCLES  = 500000000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           btn_mode,
    input  logic           btn_inc,
    alarm_setter_if.master alarm
);

    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TMO_W = (TIMEOUT_CYCLES  > 1) ? $clog2(TIMEOUT_CYCLES)  : 1;

    localparam logic [DB_W-1:0]  c_db_last  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_hours   = 2'd1;
    localparam logic [1:0] c_st_minutes = 2'd2;
    localparam logic [1:0] c_st_commit  = 2'd3;

    logic [1:0] w_btn_raw;
    logic [1:0] w_press;

    assign w_btn_raw = {btn_inc, btn_mode};

    for (genvar b = 0; b < 2; b++) begin : g_btn
        logic            r_sync1;
        logic            r_sync2;
        logic            r_level;
        logic            r_press;
        logic [DB_W-1:0] r_cnt;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
                r_level <= 1'b0;
                r_press <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_sync1 <= w_btn_raw[b];
                r_sync2 <= r_sync1;
                r_press <= 1'b0;
                if (r_sync2 == r_level) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_db_last) begin
                    // Level flips; only the rising flip is a press event.
                    r_level <= r_sync2;
                    r_press <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + DB_W'(1);
                end
            end
        end

        assign w_press[b] = r_press;
    end

    logic w_mode;
    logic w_inc;
    assign w_mode = w_press[0];
    assign w_inc  = w_press[1] & ~w_press[0];

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [TMO_W-1:0] r_tmo;
    logic             w_tmo_done;
    logic             w_in_edit;
    logic             w_nxt_edit;

    logic       r_set_alarm;
    logic [6:0] r_set_minutes;
    logic [5:0] r_set_hours;
    logic       r_editing;
    logic       r_edit_field;
    logic [6:0] r_edit_minutes;
    logic [5:0] r_edit_hours;

    assign w_tmo_done = (r_tmo == c_tmo_last);
    assign w_in_edit  = (r_state == c_st_hours) || (r_state == c_st_minutes);
    assign w_nxt_edit = (w_state_nxt == c_st_hours) || (w_state_nxt == c_st_minutes);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_mode) w_state_nxt = c_st_hours;
            end
            c_st_hours: begin
                if (w_mode)                  w_state_nxt = c_st_minutes;
                else if (!w_inc && w_tmo_done) w_state_nxt = c_st_idle;
            end
            c_st_minutes: begin
                if (w_mode)                  w_state_nxt = c_st_commit;
                else if (!w_inc && w_tmo_done) w_state_nxt = c_st_idle;
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= c_st_idle;
            r_tmo          <= '0;
            r_set_alarm    <= 1'b0;
            r_set_minutes  <= '0;
            r_set_hours    <= '0;
            r_editing      <= 1'b0;
            r_edit_field   <= 1'b0;
            r_edit_minutes <= '0;
            r_edit_hours   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_editing    <= w_nxt_edit;
            r_edit_field <= (w_state_nxt == c_st_minutes);
            r_set_alarm  <= (w_state_nxt == c_st_commit);

            // Counter runs only while staying in an edit state with no event.
            if (w_in_edit && w_nxt_edit && !w_mode && !w_inc)
                r_tmo <= r_tmo + TMO_W'(1);
            else
                r_tmo <= '0;

            if (r_state == c_st_idle && w_mode) begin
                r_edit_hours   <= r_set_hours;
                r_edit_minutes <= r_set_minutes;
            end
            if (r_state == c_st_hours && w_inc)
                r_edit_hours <= (r_edit_hours == 6'd23) ? 6'd0 : r_edit_hours + 6'd1;
            if (r_state == c_st_minutes && w_inc)
                r_edit_minutes <= (r_edit_minutes == 7'd59) ? 7'd0 : r_edit_minutes + 7'd1;
            if (r_state == c_st_minutes && w_mode) begin
                r_set_hours   <= r_edit_hours;
                r_set_minutes <= r_edit_minutes;
            end
        end
    end

    assign alarm.set_alarm    = r_set_alarm;
    assign alarm.set_minutes  = r_set_minutes;
    assign alarm.set_hours    = r_set_hours;
    assign alarm.editing      = r_editing;
    assign alarm.edit_field   = r_edit_field;
    assign alarm.edit_minutes = r_edit_minutes;
    assign alarm.edit_hours   = r_edit_hours;

endmodule

`default_nettype wire

// File: tb/tb_alarm_setter.sv
// ============================================================================
// Module      : tb_alarm_setter
// Description : Self-checking bench for alarm_setter (table rows, hand
//               sequences, randomized presses against a press-level model).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alarm_setter;

    localparam int DB  = 4;
    localparam int TMO = 100;

    logic clk      = 1'b0;
    logic rst      = 1'b0;
    logic btn_mode = 1'b0;
    logic btn_inc  = 1'b0;

    always #5 clk = ~clk;

    alarm_setter_if bus ();

    alarm_setter #(
        .DEBOUNCE_CYCLES (DB),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .alarm    (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Strobe monitor: counts set_alarm cycles, captures the committed value.
    int          n_strobe   = 0;
    int          n_long     = 0;
    logic [12:0] strobe_val = '0;
    logic        prev_alarm = 1'b0;

    always @(negedge clk) begin
        if (bus.set_alarm) begin
            n_strobe++;
            strobe_val = {bus.set_hours, bus.set_minutes};
            if (prev_alarm) n_long++;
        end
        prev_alarm = bus.set_alarm;
    end

    typedef struct {
        int m, i, n, hold, gap;
        int ed, fl, eh, em, sh, sm, st;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [28:0] pk(input int a, input int ed, input int fl,
                                       input int eh, input int em, input int sh, input int sm);
        pk = {a[0], ed[0], fl[0], eh[5:0], em[6:0], sh[5:0], sm[6:0]};
    endfunction

    function automatic logic [28:0] snap();
        snap = {bus.set_alarm, bus.editing, bus.edit_field, bus.edit_hours,
                bus.edit_minutes, bus.set_hours, bus.set_minutes};
    endfunction

    task automatic press(input int m, input int i, input int hold, input int gap);
        @(posedge clk); #1;
        btn_mode = m[0];
        btn_inc  = i[0];
        repeat (hold) @(posedge clk);
        #1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
    endtask

    // Mode press held 10 clocks; k counts edges from the first one sampling it high.
    task automatic press_measure(input int limit, output int rise, output int fall);
        rise = -1;
        fall = -1;
        @(posedge clk); #1;
        btn_mode = 1'b1;
        for (int k = 0; k < limit; k++) begin
            @(posedge clk); #1;
            if (k == 9) btn_mode = 1'b0;
            if (rise < 0 && bus.editing) rise = k;
            else if (rise >= 0 && fall < 0 && !bus.editing) fall = k;
        end
    endtask

    task automatic check_strobe(input string name, input int s0, input int exp_n,
                                input int sh, input int sm);
        if (exp_n != 0)
            check(name, {n_strobe - s0, 6'd0, strobe_val}, {exp_n, 6'd0, sh[5:0], sm[6:0]});
        else
            check(name, n_strobe - s0, 0);
    endtask

    task automatic run_rows(input int lo, input int hi);
        int s0;
        for (int r = lo; r <= hi; r++) begin
            s0 = n_strobe;
            for (int k = 0; k < tbl[r].n; k++)
                press(tbl[r].m, tbl[r].i, tbl[r].hold, tbl[r].gap);
            check($sformatf("row%0d_state", r), {3'd0, snap()},
                  {3'd0, pk(0, tbl[r].ed, tbl[r].fl, tbl[r].eh, tbl[r].em, tbl[r].sh, tbl[r].sm)});
            check_strobe($sformatf("row%0d_strobe", r), s0, tbl[r].st, tbl[r].sh, tbl[r].sm);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rise, fall, s0;
        int ph, mh, mm, sh, sm, exp_n, hold, gap;
        bit is_mode;

        //            m  i  n  hold gap   ed fl eh em sh sm st
        tbl.push_back('{0, 1, 1,  3, 10,   0, 0, 0, 0, 0, 0, 0}); // 0 inc glitch
        tbl.push_back('{1, 0, 1,  3, 10,   0, 0, 0, 0, 0, 0, 0}); // 1 mode glitch
        tbl.push_back('{0, 1, 7, 10, 10,   1, 0, 7, 0, 0, 0, 0}); // 2
        tbl.push_back('{1, 0, 1, 10, 10,   1, 1, 7, 0, 0, 0, 0}); // 3
        tbl.push_back('{0, 1,30, 10, 10,   1, 1, 7,30, 0, 0, 0}); // 4
        tbl.push_back('{1, 0, 1, 10, 10,   0, 0, 7,30, 7,30, 1}); // 5 commit 7:30
        tbl.push_back('{1, 0, 1, 10, 10,   1, 0, 7,30, 7,30, 0}); // 6
        tbl.push_back('{0, 1, 2, 10, 10,   1, 0, 9,30, 7,30, 0}); // 7
        tbl.push_back('{0, 0, 1,  0,100,   0, 0, 9,30, 7,30, 0}); // 8 timeout
        tbl.push_back('{1, 0, 1, 10, 10,   1, 0, 7,30, 7,30, 0}); // 9 reload
        tbl.push_back('{0, 1,16, 10, 10,   1, 0,23,30, 7,30, 0}); // 10
        tbl.push_back('{1, 0, 1, 10, 10,   1, 1,23,30, 7,30, 0}); // 11
        tbl.push_back('{0, 1,29, 10, 10,   1, 1,23,59, 7,30, 0}); // 12
        tbl.push_back('{1, 0, 1, 10, 10,   0, 0,23,59,23,59, 1}); // 13 commit 23:59
        tbl.push_back('{1, 0, 1, 10, 10,   1, 0,23,59,23,59, 0}); // 14
        tbl.push_back('{0, 1, 1, 10, 10,   1, 0, 0,59,23,59, 0}); // 15 hour wrap
        tbl.push_back('{1, 0, 1, 10, 10,   1, 1, 0,59,23,59, 0}); // 16
        tbl.push_back('{0, 1, 1, 10, 10,   1, 1, 0, 0,23,59, 0}); // 17 minute wrap
        tbl.push_back('{1, 0, 1, 10, 10,   0, 0, 0, 0, 0, 0, 1}); // 18 commit 0:00
        tbl.push_back('{1, 0, 1, 10, 10,   1, 0, 0, 0, 0, 0, 0}); // 19
        tbl.push_back('{0, 1, 1, 10, 10,   1, 0, 1, 0, 0, 0, 0}); // 20
        tbl.push_back('{1, 1, 1, 10, 10,   1, 1, 1, 0, 0, 0, 0}); // 21 mode wins

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        check("reset_idle", {3'd0, snap()}, 32'd0);
        check("reset_no_strobe", n_strobe, 0);

        run_rows(0, 1);

        press_measure(20, rise, fall);
        check("mode_latency", rise, 6);
        check("enter_hours", {3'd0, snap()}, {3'd0, pk(0, 1, 0, 0, 0, 0, 0)});

        run_rows(2, 13);

        s0 = n_strobe;
        press_measure(300, rise, fall);
        check("tmo_rise", rise, 6);
        check("tmo_fall", fall, 6 + TMO);
        check("tmo_state", {3'd0, snap()}, {3'd0, pk(0, 0, 0, 23, 59, 23, 59)});
        check_strobe("tmo_strobe", s0, 0, 0, 0);

        run_rows(14, 21);

        s0 = n_strobe;
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        check("async_reset", {3'd0, snap()}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("post_reset", {3'd0, snap()}, 32'd0);
        check_strobe("reset_strobe", s0, 0, 0, 0);

        // Press-level model: phase 0 idle, 1 hours, 2 minutes.
        ph = 0; mh = 0; mm = 0; sh = 0; sm = 0;
        for (int t = 0; t < 60; t++) begin
            is_mode = ($urandom_range(2) == 0);
            hold    = $urandom_range(12, 5);
            gap     = $urandom_range(20, 6);
            s0      = n_strobe;
            press(is_mode ? 1 : 0, is_mode ? 0 : 1, hold, gap);
            exp_n = 0;
            if (is_mode) begin
                if (ph == 0) begin
                    mh = sh; mm = sm; ph = 1;
                end else if (ph == 1) begin
                    ph = 2;
                end else begin
                    sh = mh; sm = mm; ph = 0; exp_n = 1;
                end
            end else if (ph == 1) begin
                mh = (mh + 1) % 24;
            end else if (ph == 2) begin
                mm = (mm + 1) % 60;
            end
            check($sformatf("rand%0d_state", t), {3'd0, snap()},
                  {3'd0, pk(0, (ph != 0) ? 1 : 0, (ph == 2) ? 1 : 0, mh, mm, sh, sm)});
            check_strobe($sformatf("rand%0d_strobe", t), s0, exp_n, sh, sm);
        end

        check("strobe_width", n_long, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
